// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, jumps, flag-based branches,
// and memory-indirect jumps with a bounded wait and sticky error flags.
module pc_sequencer #(
  parameter int unsigned AW  = 32,
  parameter int unsigned TMO = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrl_valid,
  input  logic          Jump,
  input  logic          JumpMem,
  input  logic          BranchZero,
  input  logic          BranchNeg,
  input  logic [AW-1:0] target,
  input  logic          flag_we,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic [AW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] save_pc,
  output logic          stall,
  output logic          ctrl_err,
  output logic          tmo_err
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seqState_e;

  seqState_e     state;
  seqState_e     stateNext;
  logic [AW-1:0] pcNext;
  logic [AW-1:0] pcInc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic          ctrlErrNext;
  logic          tmoErrNext;
  logic          flagZ;
  logic          flagN;
  logic [3:0]    ctrlBits;
  logic          multiCtrl;

  // Incremented PC wraps naturally at the AW-bit boundary
  assign pcInc     = pc + AW'(1);
  assign save_pc   = pcInc;
  assign stall     = (state == WAIT);
  assign ctrlBits  = {Jump, JumpMem, BranchZero, BranchNeg};
  assign multiCtrl = |(ctrlBits & (ctrlBits - 4'd1));

  // ALU flags latch on flag_we in any state; branches see the pre-edge values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagZ <= 1'b0;
      flagN <= 1'b0;
    end else if (flag_we) begin
      flagZ <= alu_zero;
      flagN <= alu_neg;
    end
  end

  // State register with PC, wait counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      cnt      <= '0;
      ctrl_err <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      cnt      <= cntNext;
      ctrl_err <= ctrlErrNext;
      tmo_err  <= tmoErrNext;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    cntNext     = cnt;
    ctrlErrNext = ctrl_err;
    tmoErrNext  = tmo_err;
    unique case (state)
      IDLE: begin
        if (ctrl_valid) begin
          if (multiCtrl) ctrlErrNext = 1'b1;
          if (Jump) begin
            pcNext = target;
          end else if (JumpMem) begin
            stateNext = WAIT;
            cntNext   = '0;
          end else if (BranchZero && flagZ) begin
            pcNext = target;
          end else if (BranchNeg && flagN) begin
            pcNext = target;
          end else begin
            pcNext = pcInc;
          end
        end
      end
      WAIT: begin
        // A response on the last allowed cycle still wins over the timeout
        if (mem_rvalid) begin
          pcNext    = mem_rdata;
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cnt == CW'(TMO - 1)) begin
          pcNext     = pcInc;
          tmoErrNext = 1'b1;
          stateNext  = IDLE;
          cntNext    = '0;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk;
  logic          rst_n;
  logic          ctrl_valid;
  logic          Jump;
  logic          JumpMem;
  logic          BranchZero;
  logic          BranchNeg;
  logic [AW-1:0] target;
  logic          flag_we;
  logic          alu_zero;
  logic          alu_neg;
  logic [AW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [AW-1:0] pc;
  logic [AW-1:0] save_pc;
  logic          stall;
  logic          ctrl_err;
  logic          tmo_err;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.AW(AW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid),
    .Jump(Jump), .JumpMem(JumpMem), .BranchZero(BranchZero), .BranchNeg(BranchNeg),
    .target(target), .flag_we(flag_we), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .pc(pc), .save_pc(save_pc), .stall(stall), .ctrl_err(ctrl_err), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    ctrl_valid = 1'b0; Jump = 1'b0; JumpMem = 1'b0; BranchZero = 1'b0; BranchNeg = 1'b0;
    target = '0; flag_we = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    checks++; if (save_pc !== 32'h1) begin failures++; $display("FAIL reset_save_pc: got %h want %h", save_pc, 32'h1); end
    checks++; if ({stall, ctrl_err, tmo_err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {stall, ctrl_err, tmo_err}); end
  endtask

  task automatic test_sequential();
    logic [AW-1:0] expPc;
    ctrl_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      expPc = AW'(i);
      checks++; if (pc !== expPc) begin failures++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, expPc); end
      checks++; if (save_pc !== expPc + 32'd1) begin failures++; $display("FAIL seq_save_pc%0d: got %h want %h", i, save_pc, expPc + 32'd1); end
    end
    ctrl_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h3) begin failures++; $display("FAIL seq_hold: got %h want %h", pc, 32'h3); end
  endtask

  task automatic test_branch_stale();
    // Z written on the same edge as the branch: not yet visible
    ctrl_valid = 1'b1; BranchZero = 1'b1; target = 32'h40;
    flag_we = 1'b1; alu_zero = 1'b1;
    step();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL bz_stale: got %h want %h", pc, 32'h4); end
    flag_we = 1'b0; alu_zero = 1'b0;
    step();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL bz_taken: got %h want %h", pc, 32'h40); end
    BranchZero = 1'b0; BranchNeg = 1'b1; target = 32'h80;
    step();
    checks++; if (pc !== 32'h41) begin failures++; $display("FAIL bn_not_taken: got %h want %h", pc, 32'h41); end
    ctrl_valid = 1'b0; BranchNeg = 1'b0; flag_we = 1'b1; alu_neg = 1'b1; alu_zero = 1'b0;
    step();
    checks++; if (pc !== 32'h41) begin failures++; $display("FAIL flag_only_hold: got %h want %h", pc, 32'h41); end
    flag_we = 1'b0; alu_neg = 1'b0; ctrl_valid = 1'b1; BranchNeg = 1'b1;
    step();
    checks++; if (pc !== 32'h80) begin failures++; $display("FAIL bn_taken: got %h want %h", pc, 32'h80); end
    BranchNeg = 1'b0; BranchZero = 1'b1; target = 32'h200;
    step();
    checks++; if (pc !== 32'h81) begin failures++; $display("FAIL bz_cleared: got %h want %h", pc, 32'h81); end
    clearInputs();
  endtask

  task automatic test_jumpmem();
    ctrl_valid = 1'b1; JumpMem = 1'b1;
    step();
    clearInputs();
    for (int i = 1; i <= 3; i++) begin
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL jm_stall%0d: got %b want 1", i, stall); end
      checks++; if (pc !== 32'h81) begin failures++; $display("FAIL jm_hold%0d: got %h want %h", i, pc, 32'h81); end
      if (i == 3) begin
        mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        ctrl_valid = 1'b1; Jump = 1'b1; target = 32'h999;
      end
      step();
    end
    checks++; if (pc !== 32'h1234) begin failures++; $display("FAIL jm_load: got %h want %h", pc, 32'h1234); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL jm_unstall: got %b want 0", stall); end
    // Response arriving while IDLE is ignored
    ctrl_valid = 1'b0; Jump = 1'b0; mem_rdata = 32'h5555;
    step();
    checks++; if (pc !== 32'h1234) begin failures++; $display("FAIL idle_rvalid: got %h want %h", pc, 32'h1234); end
    clearInputs();
  endtask

  task automatic test_timeout();
    ctrl_valid = 1'b1; Jump = 1'b1; target = 32'h5;
    step();
    Jump = 1'b0; JumpMem = 1'b1;
    step();
    clearInputs();
    for (int i = 0; i < int'(TMO) - 1; i++) step();
    checks++; if ({stall, tmo_err} !== 2'b10) begin failures++; $display("FAIL tmo_before: got %b want 10", {stall, tmo_err}); end
    step();
    checks++; if (pc !== 32'h6) begin failures++; $display("FAIL tmo_pc: got %h want %h", pc, 32'h6); end
    checks++; if ({stall, tmo_err} !== 2'b01) begin failures++; $display("FAIL tmo_flag: got %b want 01", {stall, tmo_err}); end
    ctrl_valid = 1'b1;
    step();
    step();
    checks++; if (tmo_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
    // Response on the final allowed cycle wins
    doReset();
    ctrl_valid = 1'b1; JumpMem = 1'b1;
    step();
    clearInputs();
    for (int i = 0; i < int'(TMO) - 1; i++) step();
    mem_rvalid = 1'b1; mem_rdata = 32'hABCD;
    step();
    checks++; if (pc !== 32'hABCD) begin failures++; $display("FAIL tmo_last_rvalid: got %h want %h", pc, 32'hABCD); end
    checks++; if ({stall, tmo_err} !== 2'b00) begin failures++; $display("FAIL tmo_last_flags: got %b want 00", {stall, tmo_err}); end
    clearInputs();
  endtask

  task automatic test_conflict_wrap();
    ctrl_valid = 1'b1; Jump = 1'b1; BranchNeg = 1'b1; target = 32'h10;
    step();
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL conflict_pc: got %h want %h", pc, 32'h10); end
    checks++; if (ctrl_err !== 1'b1) begin failures++; $display("FAIL conflict_err: got %b want 1", ctrl_err); end
    BranchNeg = 1'b0; target = 32'hFFFF_FFFF;
    step();
    checks++; if (save_pc !== 32'h0) begin failures++; $display("FAIL wrap_save_pc: got %h want %h", save_pc, 32'h0); end
    Jump = 1'b0;
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
    checks++; if (ctrl_err !== 1'b1) begin failures++; $display("FAIL ctrl_err_sticky: got %b want 1", ctrl_err); end
    clearInputs();
  endtask

  task automatic test_reset_mid_wait();
    ctrl_valid = 1'b1; Jump = 1'b1; target = 32'h77;
    step();
    Jump = 1'b0; JumpMem = 1'b1;
    step();
    clearInputs();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rmw_wait: got %b want 1", stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rmw_pc: got %h want %h", pc, 32'h0); end
    checks++; if ({stall, ctrl_err} !== 2'b00) begin failures++; $display("FAIL rmw_flags: got %b want 00", {stall, ctrl_err}); end
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rmw_late_rvalid: got %h want %h", pc, 32'h0); end
    clearInputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    test_reset();
    test_sequential();
    test_branch_stale();
    test_jumpmem();
    test_timeout();
    test_conflict_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter AW, default 32: PC and target width in bits.
REQ-002 SHALL have parameter TMO, default 16: maximum wait in cycles for a JumpMem memory response.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ctrl_valid, input, 1 bit: the decoded control bits are valid this cycle.
REQ-006 SHALL have ports Jump, JumpMem, BranchZero, BranchNeg, input, 1 bit each: control-block outputs for the current instruction.
REQ-007 SHALL have port target, input, AW bits: register-file value used as the jump or branch destination.
REQ-008 SHALL have ports flag_we, alu_zero, alu_neg, input, 1 bit each: ALU flag write enable and the flag values.
REQ-009 SHALL have ports mem_rdata (input, AW bits) and mem_rvalid (input, 1 bit): data-memory read return for JumpMem.
REQ-010 SHALL have port pc, output, AW bits: current instruction address (word-addressed).
REQ-011 SHALL have port save_pc, output, AW bits: pc+1, the value written back for PCtoReg.
REQ-012 SHALL have port stall, output, 1 bit: high while waiting on memory; fetch must hold.
REQ-013 SHALL have ports ctrl_err and tmo_err, output, 1 bit each: sticky error flags.

Function
REQ-014 SHALL hold flag registers Z and N, loaded from alu_zero and alu_neg on an edge where flag_we=1; otherwise they hold.
REQ-015 SHALL evaluate branches against the registered Z and N (values before the current edge), never the same-cycle ALU inputs.
REQ-016 SHALL implement states IDLE and WAIT; reset state IDLE.
REQ-017 In IDLE with ctrl_valid=0: pc SHALL hold.
REQ-018 In IDLE with ctrl_valid=1, next pc SHALL be chosen by priority Jump > JumpMem > BranchZero > BranchNeg:
  - Jump: pc <= target.
  - JumpMem: pc holds; go to WAIT; clear timeout counter.
  - BranchZero and Z=1: pc <= target.
  - BranchNeg and N=1: pc <= target.
  - Otherwise (no control bit, or branch not taken): pc <= pc+1.
REQ-019 With ctrl_valid=1 and more than one of {Jump, JumpMem, BranchZero, BranchNeg} high, ctrl_err SHALL be set; the priority outcome still applies.
REQ-020 In WAIT, stall SHALL be 1 combinationally; in IDLE, stall SHALL be 0.
REQ-021 In WAIT, ctrl_valid and all control bits SHALL be ignored; flag_we SHALL still update Z and N.
REQ-022 In WAIT with mem_rvalid=1: pc <= mem_rdata; go to IDLE.
REQ-023 In WAIT with mem_rvalid=0: the counter SHALL increment. When it reaches TMO-1 without rvalid: pc <= pc+1, tmo_err <= 1, go to IDLE.
REQ-024 mem_rvalid=1 on the timeout cycle SHALL win: load mem_rdata, no error.
REQ-025 mem_rvalid while in IDLE SHALL be ignored.
REQ-026 pc+1 SHALL wrap modulo 2^AW (all-ones -> 0) without error.
REQ-027 save_pc SHALL equal pc+1 (mod 2^AW) combinationally at all times.
REQ-028 ctrl_err and tmo_err SHALL stay set until reset.

Reset
REQ-029 rst_n=0 SHALL immediately force: pc=0, state IDLE, stall=0, Z=0, N=0, counter=0, ctrl_err=0, tmo_err=0. This applies in either state, including mid-WAIT.
REQ-030 On release, the first active edge SHALL behave as IDLE.

Verification
REQ-031 Sequential: reset, then 3 cycles of ctrl_valid=1 with no control bits -> pc 0,1,2,3; save_pc 1,2,3,4.
REQ-032 Branch on stale flags: flag_we=1 with alu_zero=1 on the same edge as BranchZero, target=0x40 -> pc+1 (not taken). Repeat the next cycle -> pc=0x40.
REQ-033 JumpMem: mem_rvalid after 3 cycles with mem_rdata=0x1234 -> stall high for 3 cycles, pc held, then pc=0x1234 and stall=0.
REQ-034 Timeout: JumpMem with no rvalid, pc=5 -> after TMO cycles pc=6, tmo_err=1 (sticky). Also: rvalid on the final cycle -> pc=mem_rdata, tmo_err=0.
REQ-035 Conflict and wrap: Jump+BranchNeg with target=0x10 -> pc=0x10, ctrl_err=1. pc=0xFFFFFFFF with no control bits -> pc=0.
REQ-036 Reset mid-WAIT: assert rst_n=0 asynchronously -> pc=0 and stall=0 before the next edge. A later mem_rvalid=1 -> pc unchanged.
